// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator drain / quantize stage:
// default widths, accumulator depth, saturation ceiling and FSM encoding.
package acc_pkg;

    localparam int PARTIAL_SUM_WIDTH_DEF = 45;
    localparam int ACC_DEPTH             = 8;
    localparam int OUT_WIDTH_DEF         = 8;
    localparam int SHIFT_WIDTH_DEF       = 6;

    // Largest value an output byte can carry; anything above clips to this.
    localparam logic [OUT_WIDTH_DEF-1:0] SAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

endpackage

// File: rtl/acc_drain_quantizer_if.sv
// Output byte stream of the drain quantizer (valid/ready handshake).
// The producer drives valid/data/idx, the consumer drives ready.
interface acc_drain_quantizer_if #(
    parameter int OUT_WIDTH = 8,
    parameter int IDX_WIDTH = 3
);

    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [IDX_WIDTH-1:0] out_idx;

    modport master (output out_valid, output out_data, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_data, input out_idx, output out_ready);

endinterface

// File: rtl/acc_drain_quantizer_quantize.sv
// psum_quantize: purely combinational shift / optional round / saturate of
// one unsigned partial sum down to an output byte.
// Build option: define ACC_DRAIN_ROUND_EN for round-half-up before saturation;
// without it the block is a plain truncating shift.
module psum_quantize
    import acc_pkg::*;
#(
    parameter int PARTIAL_SUM_WIDTH = PARTIAL_SUM_WIDTH_DEF,
    parameter int OUT_WIDTH         = OUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH       = SHIFT_WIDTH_DEF
) (
    input  logic [PARTIAL_SUM_WIDTH-1:0] psum,
    input  logic [SHIFT_WIDTH-1:0]       shift_amt,
    output logic [OUT_WIDTH-1:0]         q_out
);

    // One spare bit so the rounding add can never overflow.
    localparam int WIDE = PARTIAL_SUM_WIDTH + 1;

    logic [WIDE-1:0] q_wide;

`ifdef ACC_DRAIN_ROUND_EN
    logic [WIDE-1:0] rounded;

    // Round half-up: add half a result LSB before shifting (no-op for shift 0).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rounded = {1'b0, psum};
        if (shift_amt != '0) begin
            rounded = rounded + (WIDE'(1) << (shift_amt - 1'b1));
        end
        q_wide = rounded >> shift_amt;
    end
`else
    // Truncating shift; shifts at or beyond the operand width yield zero.
    always_comb begin
        q_wide = {1'b0, psum} >> shift_amt;
    end
`endif

    // Saturate on the full-width result so no high bits are lost before the compare.
    always_comb begin
        q_out = (|q_wide[WIDE-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}} : q_wide[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/acc_drain_quantizer.sv
// acc_drain_quantizer: on start, reads accumulator entries 0..SIZE-1 in order,
// quantizes each through psum_quantize and streams the bytes out over a
// valid/ready interface. Two register stages (S1 = raw read, S2 = output)
// with full backpressure; busy spans start..done, done pulses once per drain.
// Build option: ACC_DRAIN_ROUND_EN enables rounding inside psum_quantize.
module acc_drain_quantizer
    import acc_pkg::*;
#(
    parameter int SIZE              = ACC_DEPTH,
    parameter int PARTIAL_SUM_WIDTH = PARTIAL_SUM_WIDTH_DEF,
    parameter int OUT_WIDTH         = OUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH       = SHIFT_WIDTH_DEF,
    localparam int ADDR_WIDTH       = $clog2(SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [SHIFT_WIDTH-1:0]       shift_amt,
    output logic [ADDR_WIDTH-1:0]        acc_rd_addr,
    input  logic [PARTIAL_SUM_WIDTH-1:0] acc_rd_data,
    acc_drain_quantizer_if.master        out_if,
    output logic                         busy,
    output logic                         done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    drain_state_e state, state_nxt;

    logic                         accept_start;
    logic                         issue;
    logic                         last_issue;
    logic                         flush_done;

    logic [ADDR_WIDTH-1:0]        rd_ptr;
    logic [SHIFT_WIDTH-1:0]       shift_q;

    logic                         s1_valid;
    logic [PARTIAL_SUM_WIDTH-1:0] s1_data;
    logic [ADDR_WIDTH-1:0]        s1_idx;
    logic                         s2_valid;
    logic [OUT_WIDTH-1:0]         s2_data;
    logic [ADDR_WIDTH-1:0]        s2_idx;
    logic [OUT_WIDTH-1:0]         q_data;

    logic                         s2_load;
    logic                         s1_adv;

    // Stall network: S2 refills when empty or drained; S1 follows S2 or fills a bubble.
    always_comb begin
        s2_load = !s2_valid || out_if.out_ready;
        s1_adv  = s2_load || !s1_valid;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept_start) state_nxt = DRAIN;
            DRAIN:   if (last_issue)   state_nxt = FLUSH;
            FLUSH:   if (flush_done)   state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // FSM outputs and control strobes. A start coinciding with done is dropped.
    always_comb begin
        busy         = (state != IDLE);
        accept_start = (state == IDLE) && start && !done;
        issue        = (state == DRAIN) && s1_adv;
        last_issue   = issue && (rd_ptr == LAST_ADDR);
        flush_done   = (state == FLUSH) && !s1_valid && (!s2_valid || out_if.out_ready);
    end

    // Control registers: shift latched on start, read pointer, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            shift_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= flush_done;
            if (accept_start) begin
                shift_q <= shift_amt;
                rd_ptr  <= '0;
            end else if (issue && (rd_ptr != LAST_ADDR)) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Read address parks on the last entry read; it never wraps past SIZE-1.
    assign acc_rd_addr = rd_ptr;

    // Pipeline registers: S1 holds the raw read, S2 the quantized output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_idx   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= issue;
                if (issue) begin
                    s1_data <= acc_rd_data;
                    s1_idx  <= rd_ptr;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= q_data;
                    s2_idx  <= s1_idx;
                end
            end
        end
    end

    psum_quantize #(
        .PARTIAL_SUM_WIDTH (PARTIAL_SUM_WIDTH),
        .OUT_WIDTH         (OUT_WIDTH),
        .SHIFT_WIDTH       (SHIFT_WIDTH)
    ) u_quantize (
        .psum      (s1_data),
        .shift_amt (shift_q),
        .q_out     (q_data)
    );

    assign out_if.out_valid = s2_valid;
    assign out_if.out_data  = s2_data;
    assign out_if.out_idx   = s2_idx;

endmodule

// File: tb/tb_acc_drain_quantizer.sv
// Self-checking bench for acc_drain_quantizer: randomized accumulator
// contents and handshake patterns, checked against an arithmetic model of
// shift / round / saturate and the expected beat order and timing.
module tb_acc_drain_quantizer;
    import acc_pkg::*;

    localparam int PSW = 45;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [5:0]     shift_amt;
    logic [2:0]     acc_rd_addr;
    logic [PSW-1:0] acc_rd_data;
    logic           busy;
    logic           done;

    acc_drain_quantizer_if #(.OUT_WIDTH(8), .IDX_WIDTH(3)) out_if ();

    logic [PSW-1:0] mem [8];
    assign acc_rd_data = mem[acc_rd_addr];

    always #5 clk = ~clk;

    acc_drain_quantizer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .shift_amt   (shift_amt),
        .acc_rd_addr (acc_rd_addr),
        .acc_rd_data (acc_rd_data),
        .out_if      (out_if),
        .busy        (busy),
        .done        (done)
    );

    int total = 0;
    int bad   = 0;

    // Observations gathered by run_drain.
    logic [7:0] bd[$];
    logic [2:0] bi[$];
    int         bc[$];
    int         done_cnt;
    int         done_cyc;
    int         stall_err;
    int         busy_post;
    logic       busy_at_done;
    logic       rst_valid_after;
    logic       rst_busy_after;

    // Reference: plain unsigned arithmetic on a 64-bit value.
    function automatic logic [7:0] ref_q(input logic [PSW-1:0] p, input logic [5:0] sh);
        logic [63:0] w;
        logic [63:0] q;
        w = 64'(p);
`ifdef ACC_DRAIN_ROUND_EN
        if (sh == 6'd0) q = w;
        else            q = (w + (64'd1 << (sh - 1))) >> sh;
`else
        q = w >> sh;
`endif
        return (q > 64'(SAT_MAX)) ? SAT_MAX : q[7:0];
    endfunction

    function automatic logic [PSW-1:0] rnd_psum();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return PSW'(r >> $urandom_range(19, 63));
    endfunction

    // Runs one drain. mode: 0 ready high, 1 fixed 1,0,0,1,0,1 pattern, 2 random.
    // extra_cyc: cycle of a second start (shift 7); rst_cyc: cycle of a reset pulse.
    task automatic run_drain(input logic [5:0] sh, input int mode, input int extra_cyc, input int rst_cyc);
        int         pat [6];
        logic       pv, pr, v, rdy;
        logic [7:0] pd;
        logic [2:0] pi;
        pat = '{1, 0, 0, 1, 0, 1};
        bd.delete(); bi.delete(); bc.delete();
        done_cnt = 0; done_cyc = -1; stall_err = 0; busy_post = 0;
        busy_at_done = 1'b1; rst_valid_after = 1'b1; rst_busy_after = 1'b1;
        pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
        @(negedge clk);
        start = 1'b1; shift_amt = sh; out_if.out_ready = 1'b1;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            start = (cyc == extra_cyc);
            if (cyc == extra_cyc) shift_amt = 6'd7;
            rst = (cyc == rst_cyc);
            v = out_if.out_valid;
            if (pv && !pr && (v !== 1'b1 || out_if.out_data !== pd || out_if.out_idx !== pi))
                stall_err++;
            if (cyc == rst_cyc + 1) begin
                rst_valid_after = v;
                rst_busy_after  = busy;
            end
            if (done_cnt > 0 && busy === 1'b1) busy_post++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = pat[(cyc - 1) % 6] != 0;
            else                rdy = $urandom_range(0, 1) != 0;
            out_if.out_ready = rdy;
            if (v === 1'b1 && rdy) begin
                bd.push_back(out_if.out_data);
                bi.push_back(out_if.out_idx);
                bc.push_back(cyc);
            end
            pv = v; pr = rdy; pd = out_if.out_data; pi = out_if.out_idx;
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            if (rst_cyc > 0 && cyc >= rst_cyc + 3) break;
        end
        start = 1'b0; rst = 1'b0; out_if.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; shift_amt = '0; out_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (acc_rd_addr !== 3'd0) begin bad++; $display("FAIL reset_addr: got %0d expected 0", acc_rd_addr); end
        total++; if (out_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", out_if.out_valid); end
        total++; if (out_if.out_data !== 8'd0) begin bad++; $display("FAIL reset_data: got %0d expected 0", out_if.out_data); end
        total++; if (out_if.out_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d expected 0", out_if.out_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [8];
        exp = '{8'd0, 8'd100, 8'd255, 8'd255, 8'd255, 8'd255, 8'd17, 8'd255};
        mem[0] = 45'd0;   mem[1] = 45'd100; mem[2] = 45'd255;  mem[3] = 45'd256;
        mem[4] = 45'd1000; mem[5] = 45'd1 << 44; mem[6] = 45'd17; mem[7] = 45'd300;
        run_drain(6'd0, 0, -1, -1);
        total++; if (bd.size() != 8) begin bad++; $display("FAIL basic_count: got %0d expected 8", bd.size()); end
        for (int i = 0; i < 8 && i < bd.size(); i++) begin
            total++; if (bd[i] !== exp[i]) begin bad++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, bd[i], exp[i]); end
            total++; if (bi[i] !== 3'(i)) begin bad++; $display("FAIL basic_idx[%0d]: got %0d expected %0d", i, bi[i], i); end
            total++; if (bc[i] != 3 + i) begin bad++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, bc[i], 3 + i); end
        end
        total++; if (done_cyc != 11) begin bad++; $display("FAIL basic_done_cycle: got %0d expected 11", done_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
    endtask

    task automatic test_shift();
        logic [7:0] want0, want1;
        for (int i = 0; i < 8; i++) mem[i] = (i % 2 == 0) ? 45'h1F8 : 45'h1F7;
`ifdef ACC_DRAIN_ROUND_EN
        want0 = 8'd32; want1 = 8'd31;
`else
        want0 = 8'd31; want1 = 8'd31;
`endif
        run_drain(6'd4, 0, -1, -1);
        total++; if (bd.size() != 8) begin bad++; $display("FAIL shift_count: got %0d expected 8", bd.size()); end
        for (int i = 0; i < 8 && i < bd.size(); i++) begin
            total++;
            if (bd[i] !== ((i % 2 == 0) ? want0 : want1)) begin
                bad++; $display("FAIL shift_data[%0d]: got %0d expected %0d", i, bd[i], (i % 2 == 0) ? want0 : want1);
            end
        end
    endtask

    task automatic test_backpressure(input int mode);
        logic [5:0] sh;
        sh = 6'($urandom_range(0, 20));
        for (int i = 0; i < 8; i++) mem[i] = rnd_psum();
        run_drain(sh, mode, -1, -1);
        total++; if (bd.size() != 8) begin bad++; $display("FAIL bp%0d_count: got %0d expected 8", mode, bd.size()); end
        for (int i = 0; i < 8 && i < bd.size(); i++) begin
            total++; if (bi[i] !== 3'(i)) begin bad++; $display("FAIL bp%0d_idx[%0d]: got %0d expected %0d", mode, i, bi[i], i); end
            total++; if (bd[i] !== ref_q(mem[i], sh)) begin bad++; $display("FAIL bp%0d_data[%0d]: got %0d expected %0d", mode, i, bd[i], ref_q(mem[i], sh)); end
        end
        total++; if (stall_err != 0) begin bad++; $display("FAIL bp%0d_stable: got %0d changes expected 0", mode, stall_err); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp%0d_done_count: got %0d expected 1", mode, done_cnt); end
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < 8; i++) mem[i] = rnd_psum();
        run_drain(6'd3, 0, 5, -1);
        total++; if (bd.size() != 8) begin bad++; $display("FAIL busy_start_count: got %0d expected 8", bd.size()); end
        for (int i = 0; i < 8 && i < bd.size(); i++) begin
            total++; if (bd[i] !== ref_q(mem[i], 6'd3)) begin bad++; $display("FAIL busy_start_data[%0d]: got %0d expected %0d", i, bd[i], ref_q(mem[i], 6'd3)); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
        // A start raised in the done cycle must not launch a new drain.
        run_drain(6'd3, 0, 11, -1);
        total++; if (done_cyc != 11) begin bad++; $display("FAIL done_start_cycle: got %0d expected 11", done_cyc); end
        total++; if (busy_post != 0) begin bad++; $display("FAIL done_start_ignored: got %0d busy cycles expected 0", busy_post); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) mem[i] = rnd_psum();
        run_drain(6'd2, 0, -1, 6);
        total++; if (rst_valid_after !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b expected 0", rst_valid_after); end
        total++; if (rst_busy_after !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", rst_busy_after); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rstmid_done: got %0d expected 0", done_cnt); end
        run_drain(6'd2, 2, -1, -1);
        total++; if (bd.size() != 8) begin bad++; $display("FAIL rstmid_redo_count: got %0d expected 8", bd.size()); end
        for (int i = 0; i < 8 && i < bd.size(); i++) begin
            total++; if (bi[i] !== 3'(i)) begin bad++; $display("FAIL rstmid_redo_idx[%0d]: got %0d expected %0d", i, bi[i], i); end
            total++; if (bd[i] !== ref_q(mem[i], 6'd2)) begin bad++; $display("FAIL rstmid_redo_data[%0d]: got %0d expected %0d", i, bd[i], ref_q(mem[i], 6'd2)); end
        end
    endtask

    task automatic test_large_shift();
        for (int i = 0; i < 8; i++) mem[i] = rnd_psum() | 45'd1 | (45'd1 << 44);
        run_drain(6'd50, 1, -1, -1);
        total++; if (bd.size() != 8) begin bad++; $display("FAIL large_shift_count: got %0d expected 8", bd.size()); end
        for (int i = 0; i < 8 && i < bd.size(); i++) begin
            total++; if (bd[i] !== 8'd0) begin bad++; $display("FAIL large_shift_data[%0d]: got %0d expected 0", i, bd[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_backpressure(1);
        test_backpressure(2);
        test_backpressure(2);
        test_start_while_busy();
        test_reset_mid();
        test_large_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_drain_quantizer.md
Name: acc_drain_quantizer

Overview:
- Downstream stage of the accumulator.
- On a start pulse, drains the 8 accumulator entries in address order 0..7.
- Each entry is an unsigned partial sum. The block right-shifts it by a programmable amount, optionally rounds, and saturates it to 8 bits.
- Results go out over a valid/ready stream to the activation/unified-buffer write port, so the next layer's input bytes are produced from finished partial sums.

Parameters:
- SIZE, 8: array dimension; number of accumulator entries to drain.
- PARTIAL_SUM_WIDTH, 45: width of one accumulator entry, ((8*4)+4)+SIZE+1.
- OUT_WIDTH, 8: quantized output width.
- SHIFT_WIDTH, 6: width of the shift-amount input.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to drain all entries; ignored while busy.
- shift_amt  in  SHIFT_WIDTH  right-shift amount; sampled only on an accepted start.
- acc_rd_addr  out  3  accumulator read address.
- acc_rd_data  in  PARTIAL_SUM_WIDTH  accumulator read data; combinational from acc_rd_addr in the same cycle.
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_data  out  OUT_WIDTH  quantized value.
- out_idx  out  3  accumulator address the beat came from.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: acc_rd_addr=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0. FSM goes to IDLE and all pipeline valids clear.
- FSM states:
  - IDLE: start=1 latches shift_amt, sets rd_ptr=0, busy=1, and goes to DRAIN.
  - DRAIN: issues reads. Once rd_ptr=SIZE-1 has been captured, goes to FLUSH.
  - FLUSH: waits until the pipeline is empty and the output is accepted, then pulses done, clears busy, and returns to IDLE.
- Pipeline, two register stages:
  - S1 captures acc_rd_data and rd_ptr.
  - S2 (the output register) holds the quantized value.
- Stall rule:
  - S2 loads when it is empty or being accepted (out_ready high).
  - S1 advances when S2 loads or S1 is empty.
  - A read is issued, and rd_ptr increments, only in DRAIN when S1 advances.
  - No beat is dropped or duplicated under any out_ready pattern.
- Latency: start at cycle 0 → first read at cycle 1 → S1 at 2 → out_valid at cycle 3. With out_ready held high, throughput is 1 beat/cycle and 8 beats arrive on cycles 3..10.
- Arithmetic, all unsigned:
  - q = psum >> shift_amt.
  - If q > 2^OUT_WIDTH-1, out_data = 2^OUT_WIDTH-1 (255); otherwise out_data = q[OUT_WIDTH-1:0].
  - shift_amt >= PARTIAL_SUM_WIDTH gives q=0.
  - The saturation compare uses the full PARTIAL_SUM_WIDTH result; there is no truncation before the compare.
- acc_rd_addr holds its last value when not reading. It is 3 bits wide; SIZE=8 uses the full range, with no wrap beyond 7.
- Simultaneous events:
  - start during busy is ignored, and shift_amt is not re-sampled.
  - start in the same cycle as done is ignored; a new start is required after busy falls.
- Reset during DRAIN or FLUSH aborts immediately: out_valid drops the next cycle and no done pulse is produced.
- out_data and out_idx stay stable while out_valid && !out_ready.

Optional Feature:
- Macro: ACC_DRAIN_ROUND_EN.
- Defined: round half-up before saturation, q = (psum + (1 << (shift_amt-1))) >> shift_amt when shift_amt > 0.
  - The add is computed at PARTIAL_SUM_WIDTH+1 bits, so there is no overflow.
  - shift_amt=0 is unchanged.
- Undefined: truncating shift only. No rounding adder is present.

Decomposition:
- Shared package acc_pkg holds:
  - constants PARTIAL_SUM_WIDTH_DEF=45, ACC_DEPTH=8, OUT_WIDTH_DEF=8;
  - FSM state typedef {IDLE, DRAIN, FLUSH} as a 2-bit encoding;
  - saturation max value.
- One sub-module: psum_quantize. It is purely combinational: shift, optional round, saturate. It is instantiated in the S1→S2 path and can be unit-tested standalone.

Test Plan:
- Basic drain:
  - Stimulus: entries 0..7 = {0,100,255,256,1000,2^44,17,300}, shift_amt=0, out_ready=1.
  - Required: out_data = {0,100,255,255,255,255,17,255}; out_idx 0..7; out_valid on cycles 3..10; done on cycle 11.
- Shift:
  - Stimulus: shift_amt=4, entry=0x1F8.
  - Required: out_data = 0x1F = 31; with ACC_DRAIN_ROUND_EN, 0x1F8 gives 32 and 0x1F7 gives 31.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,0,1... throughout a drain.
  - Required: exactly 8 beats, in order, with no duplicates, and stable data while stalled.
- Start while busy:
  - Stimulus: second start with shift_amt=7 at cycle 5.
  - Required: ignored; all outputs use the original shift and only one done pulse occurs.
- Reset mid-drain:
  - Stimulus: rst at cycle 6 after start.
  - Required: next cycle out_valid=0 and busy=0, with no done; a fresh start then drains all 8 entries correctly.
- Large shift:
  - Stimulus: shift_amt=50, all entries nonzero.
  - Required: all out_data = 0.
